// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the round-robin ALU sharing arbiter.
package alu_share_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Bit positions inside the {zero, overflow, negative, carry} flag bundle
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_W = 4;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_BITS_SIZE  = 32;
  localparam int unsigned DEF_CNTRL_SIZE = 4;
  localparam int unsigned DEF_ALU_LAT    = 2;
  localparam int unsigned CNT_W          = 3;

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr, with wrap.
module alu_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  always_comb begin
    int unsigned       k;
    logic [ID_W-1:0]   kk;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    k         = 0;
    kk        = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      k  = (32'(ptr) + i) % N;
      kk = ID_W'(k);
      if (!grant_any && valid[kk]) begin
        grant_any = 1'b1;
        grant_idx = kk;
        grant[kk] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one registered ALU datapath between NUM_REQ requesters, one op at a time.
// Optional perf counters (perf_ops, perf_stall) enabled by ALU_SHARE_ARB_PERF_EN.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned BITS_SIZE  = DEF_BITS_SIZE,
  parameter int unsigned CNTRL_SIZE = DEF_CNTRL_SIZE,
  parameter int unsigned ALU_LAT    = DEF_ALU_LAT,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*BITS_SIZE-1:0]    req_a,
  input  logic [NUM_REQ*BITS_SIZE-1:0]    req_b,
  input  logic [NUM_REQ*CNTRL_SIZE-1:0]   req_cntrl,
  input  logic [NUM_REQ-1:0]              req_cin,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [BITS_SIZE-1:0]            rsp_out,
  output logic [FLAG_W-1:0]               rsp_flags,
  output logic [BITS_SIZE-1:0]            alu_a,
  output logic [BITS_SIZE-1:0]            alu_b,
  output logic [CNTRL_SIZE-1:0]           alu_cntrl,
  output logic                            alu_cin,
  input  logic [BITS_SIZE-1:0]            alu_out,
  input  logic                            alu_zero,
  input  logic                            alu_overflow,
  input  logic                            alu_negative,
  input  logic                            alu_carry
`ifdef ALU_SHARE_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_ops,
  output logic [31:0]                     perf_stall
`endif
);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [ID_W-1:0]         ptr, id_q;
  logic [NUM_REQ-1:0]      gnt;
  logic [ID_W-1:0]         gnt_idx;
  logic                    gnt_any;
  logic                    xfer, capture, rsp_done;
  logic [BITS_SIZE-1:0]    a_sel, b_sel;
  logic [CNTRL_SIZE-1:0]   c_sel;
  logic                    ci_sel;

  alu_rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .valid     (req_valid),
    .ptr       (ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any)       state_nxt = BUSY;
      BUSY:    if (cnt == '0)     state_nxt = RESP;
      RESP:    if (rsp_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Per-state strobes; req_ready is combinational and only offered in IDLE
  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        xfer      = gnt_any;
      end
      BUSY:    capture  = (cnt == '0);
      RESP:    rsp_done = rsp_ready;
      default: ;
    endcase
  end

  // Operand mux from the one-hot grant
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    c_sel  = '0;
    ci_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_sel  = req_a[i*BITS_SIZE +: BITS_SIZE];
        b_sel  = req_b[i*BITS_SIZE +: BITS_SIZE];
        c_sel  = req_cntrl[i*CNTRL_SIZE +: CNTRL_SIZE];
        ci_sel = req_cin[i];
      end
    end
  end

  // Operand, counter, pointer and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cntrl <= '0;
      alu_cin   <= 1'b0;
      id_q      <= '0;
      ptr       <= ID_W'(NUM_REQ - 1);
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_out   <= '0;
      rsp_flags <= '0;
    end else begin
      if (xfer) begin
        alu_a     <= a_sel;
        alu_b     <= b_sel;
        alu_cntrl <= c_sel;
        alu_cin   <= ci_sel;
        id_q      <= gnt_idx;
        ptr       <= gnt_idx;
        cnt       <= CNT_W'(ALU_LAT);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        rsp_valid         <= 1'b1;
        rsp_id            <= id_q;
        rsp_out           <= alu_out;
        rsp_flags[FLAG_Z] <= alu_zero;
        rsp_flags[FLAG_V] <= alu_overflow;
        rsp_flags[FLAG_N] <= alu_negative;
        rsp_flags[FLAG_C] <= alu_carry;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SHARE_ARB_PERF_EN
  // Completed-response and response-stall counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (rsp_done)                     perf_ops   <= perf_ops + 32'd1;
      if (state == RESP && !rsp_ready)  perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  // Counters absent in this build
`endif

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one registered ALU datapath (operand/control input flops, ALU, flag/result output flops) between NUM_REQ requesters.
- Round-robin grant, valid/ready request handshake, single response channel tagged with requester id.
- Sequences one operation at a time: latches operands, holds them stable for the datapath latency, captures result and flags, returns them.
- Sits between requester blocks and the registered ALU wrapper; shares that wrapper's clk/reset.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- BITS_SIZE, 32, operand/result width
- CNTRL_SIZE, 4, ALU control width
- ALU_LAT, 2, cycles from operands at alu_* outputs to result visible at alu_* inputs (1..7)
- ID_W, $clog2(NUM_REQ), response id width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*BITS_SIZE  operand A, slice i belongs to requester i
- req_b  in  NUM_REQ*BITS_SIZE  operand B
- req_cntrl  in  NUM_REQ*CNTRL_SIZE  ALU control
- req_cin  in  NUM_REQ  carry in
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the originating requester
- rsp_out  out  BITS_SIZE  ALU result
- rsp_flags  out  4  {zero, overflow, negative, carry}
- alu_a, alu_b  out  BITS_SIZE  to datapath operand inputs
- alu_cntrl  out  CNTRL_SIZE  to datapath control input
- alu_cin  out  1  to datapath carry input
- alu_out  in  BITS_SIZE  from datapath result
- alu_zero, alu_overflow, alu_negative, alu_carry  in  1  from datapath flags

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - req_ready = 0, rsp_valid = 0
  - rsp_id, rsp_out, rsp_flags = 0
  - alu_* = 0
  - rr pointer = NUM_REQ-1, so requester 0 wins first.
- States:
  - IDLE
  - BUSY (down-counter cnt, 3 bits)
  - RESP
- IDLE:
  - Grant = first asserted req_valid searching from pointer+1 with wrap.
  - req_ready[grant] = 1 combinationally, only in IDLE and only when that requester's req_valid = 1.
  - Transfer = req_valid[i] & req_ready[i]. On transfer:
    - latch slice i into alu_a/alu_b/alu_cntrl/alu_cin registers
    - latch id = i
    - pointer <= i
    - cnt <= ALU_LAT
    - go to BUSY.
  - No valid request: stay in IDLE.
- BUSY:
  - req_ready = 0. alu_* held stable.
  - cnt decrements each cycle.
  - When cnt == 0: capture alu_out and the flags into the rsp regs, set rsp_valid, go to RESP.
  - Latency: rsp_valid rises ALU_LAT+1 edges after the transfer edge.
- RESP:
  - rsp_valid held with stable rsp_* until the edge where rsp_ready = 1.
  - On that edge: rsp_valid <= 0, go to IDLE.
  - No new grant in the RESP cycle, so minimum issue interval is ALU_LAT+3 cycles.
- alu_* hold the last issued operation while idle; they are not cleared.
- Requester drops req_valid without handshake: legal. No grant occurs and the pointer is unchanged.
- A requester's operands may change while it is not being granted. Only values present at the transfer edge are used.
- Reset mid-operation: in-flight operation and pending response are discarded, with no rsp_valid. Datapath registers on the same reset net also clear.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 operations.

Optional Feature:
- Macro: ALU_SHARE_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_ops (32-bit): count of completed responses, incremented at the rsp handshake edge.
  - Adds perf_stall (32-bit): cycles in RESP with rsp_ready = 0.
  - Both wrap at 2^32, reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package alu_share_arb_pkg:
  - state enum {IDLE, BUSY, RESP}
  - flag index constants FLAG_Z=3, FLAG_V=2, FLAG_N=1, FLAG_C=0
  - default widths
- Sub-module alu_rr_pick: combinational round-robin picker. Inputs: valid vector, pointer. Outputs: grant one-hot, grant index, any-grant.

Test Plan:
- Single request: reset, req_valid[2] = 1, a = 5, b = 7, cin = 1, with a bench 2-stage add model -> req_ready[2] pulses 1 cycle; rsp_valid 3 edges later; rsp_id = 2, rsp_out = 13, flags = 0000.
- All four valid continuously, rsp_ready = 1 -> grant order 0,1,2,3,0; each response spaced ALU_LAT+3 = 5 cycles.
- Backpressure: rsp_ready low for 10 cycles -> rsp_* stable; req_ready stays 0; req_valid[1] waiting gets no grant until after the rsp handshake.
- Flags: a = 0x7FFFFFFF, b = 1, cin = 0, add model -> rsp_out = 0x80000000, flags = {0,1,1,0}; a = 0xFFFFFFFF, b = 1 -> rsp_out = 0, flags = {1,0,0,1}.
- Reset mid-BUSY: reset at cnt = 1 -> no rsp_valid; alu_* = 0 next cycle; next grant goes to requester 0.
- Operand stability: req_a[0] changed every cycle after transfer -> alu_a constant until next transfer; rsp_out reflects the latched value.
